cv32e40x_flush_sequencer: RTL

Parametrised successor to the controller's single fence.i flush request/acknowledge handshake. It runs one flush operation across NUM_CH downstream agents, for example write buffer, I-side prefetch, D-side buffer and eXtension unit. Agents are served either one at a time in ascending index order or all in parallel. An optional timeout lets an operation complete even if an agent never acknowledges. It sits beside the controller FSM, which pulses start_i and waits for done_o before resuming fetch.

---
 rtl/cv32e40x_flush_sequencer_pkg.sv | 17 +
 rtl/cv32e40x_flush_timer.sv | 30 +++
 rtl/cv32e40x_flush_sequencer.sv | 119 +++++++++++
 3 files changed

// File: rtl/cv32e40x_flush_sequencer_pkg.sv
// Shared types and helpers for the flush sequencer.
package cv32e40x_flush_sequencer_pkg;

  localparam int unsigned MAX_CH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } flush_seq_state_e;

  // Isolate the lowest set bit of a channel mask (zero stays zero).
  function automatic logic [MAX_CH-1:0] lowest_set(input logic [MAX_CH-1:0] v);
    return v & (~v + MAX_CH'(1));
  endfunction

endpackage

// File: rtl/cv32e40x_flush_timer.sv
// Saturating wait counter; expired_c flags the cycle that reaches MAX_COUNT cycles of enable.
module cv32e40x_flush_timer #(
  parameter int unsigned MAX_COUNT = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic en,
  output logic expired_c
);

  localparam int unsigned CNT_W = $clog2(MAX_COUNT + 1);

  logic [CNT_W-1:0] cnt_q;

  // Count enabled cycles, saturating at MAX_COUNT; clear has priority.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (en && (cnt_q != CNT_W'(MAX_COUNT))) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  // The current cycle is the MAX_COUNT-th enabled one.
  assign expired_c = en && (cnt_q >= CNT_W'(MAX_COUNT - 1));

endmodule

// File: rtl/cv32e40x_flush_sequencer.sv
// Runs one flush operation over NUM_CH agents, serially or in parallel, with optional timeout.
module cv32e40x_flush_sequencer
  import cv32e40x_flush_sequencer_pkg::*;
#(
  parameter int unsigned NUM_CH         = 2,
  parameter int unsigned SEQUENTIAL     = 1,
  parameter int unsigned TIMEOUT_CYCLES = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic [NUM_CH-1:0] ch_en_i,
  output logic [NUM_CH-1:0] flush_req_o,
  input  logic [NUM_CH-1:0] flush_ack_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [NUM_CH-1:0] ch_timeout_o
);

  flush_seq_state_e  state_q, state_d;
  logic [NUM_CH-1:0] pending_q, pending_d;
  logic [NUM_CH-1:0] req_d, completed, timed_out;
  logic              busy_d, done_d, expired;

  // Next state, pending mask and next registered outputs.
  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    timed_out = '0;
    completed = flush_req_o & flush_ack_i;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          pending_d = ch_en_i;
          state_d   = (ch_en_i != '0) ? REQ : DONE;
        end
      end
      REQ: begin
        // An ack in the expiry cycle counts as completion, not timeout.
        if (expired) timed_out = flush_req_o & ~flush_ack_i;
        pending_d = pending_q & ~(completed | timed_out);
        if (pending_d == '0) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (state_d != REQ) begin
      req_d = '0;
    end else if (SEQUENTIAL != 0) begin
      req_d = NUM_CH'(lowest_set(MAX_CH'(pending_d)));
    end else begin
      req_d = pending_d;
    end
    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      pending_q   <= '0;
      flush_req_o <= '0;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
    end else begin
      state_q     <= state_d;
      pending_q   <= pending_d;
      flush_req_o <= req_d;
      busy_o      <= busy_d;
      done_o      <= done_d;
    end
  end

  generate
    if (TIMEOUT_CYCLES > 0) begin : g_timer
      logic              tmr_clear, accept;
      logic [NUM_CH-1:0] ch_timeout_q;

      // Serial mode restarts the wait whenever a different channel takes the request.
      assign tmr_clear = (state_q != REQ) || ((SEQUENTIAL != 0) && (req_d != flush_req_o));
      assign accept    = (state_q == IDLE) && start_i;

      cv32e40x_flush_timer #(
        .MAX_COUNT (TIMEOUT_CYCLES)
      ) u_timer (
        .clk       (clk),
        .rst       (rst),
        .clear     (tmr_clear),
        .en        (state_q == REQ),
        .expired_c (expired)
      );

      // Sticky abandoned-channel flags, cleared by the next accepted start.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          ch_timeout_q <= '0;
        end else if (accept) begin
          ch_timeout_q <= '0;
        end else begin
          ch_timeout_q <= ch_timeout_q | timed_out;
        end
      end

      assign ch_timeout_o = ch_timeout_q;
    end else begin : g_no_timer
      assign expired      = 1'b0;
      assign ch_timeout_o = '0;
    end
  endgenerate

  a_onehot_req: assert property (@(posedge clk) disable iff (rst)
    (SEQUENTIAL == 0) || $onehot0(flush_req_o));
  a_idle_no_req: assert property (@(posedge clk) disable iff (rst)
    (state_q == IDLE) |-> (flush_req_o == '0));
  a_done_pulse: assert property (@(posedge clk) disable iff (rst)
    done_o |=> !done_o);

endmodule
